spi_sample_receiver: RTL and testbench

- Receives the SPI stream that the wave generator drives on uio_out[7:5] (spi_clk, spi_mosi, spi_cs); it is the device-side (DAC-side) end of that link.
- Oversamples the three SPI lines on the system clock and shifts in MSB-first words.
- Presents each completed word on a valid/ready port with overrun and frame-error reporting.
- Used as the sink model in system benches and as the receive front end of a companion DAC tile.

---
 rtl/spi_rx_pkg.sv | 21 ++
 rtl/spi_rx_frontend.sv | 46 ++++
 rtl/spi_sample_receiver.sv | 99 +++++++++
 tb/tb_spi_sample_receiver.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_rx_pkg.sv
// Shared types and helpers for the SPI sample receiver.
package spi_rx_pkg;

    localparam int unsigned DATA_WIDTH_DEFAULT = 8;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Ceiling log2, used to size the bit counter.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/spi_rx_frontend.sv
// SPI pin input stage: optional two-flop synchronizer (SPI_RX_SYNC_EN),
// one-cycle delayed spi_clk and rising-edge detection.
module spi_rx_frontend (
    input  logic clk,
    input  logic rst_n,
    input  logic spi_clk_i,
    input  logic spi_mosi_i,
    input  logic spi_cs_i,
    output logic mosi,
    output logic cs,
    output logic rise
);

    logic [2:0] s0;     // {clk, mosi, cs}
    logic       clk_q;

`ifdef SPI_RX_SYNC_EN
    logic [2:0] meta;
    logic [2:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 3'b001;
            sync <= 3'b001;
        end else begin
            meta <= {spi_clk_i, spi_mosi_i, spi_cs_i};
            sync <= meta;
        end
    end

    assign s0 = sync;
`else
    assign s0 = {spi_clk_i, spi_mosi_i, spi_cs_i};
`endif

    // Only the clock line needs a delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) clk_q <= 1'b0;
        else        clk_q <= s0[2];
    end

    assign mosi = s0[1];
    assign cs   = s0[0];
    assign rise = s0[2] & ~clk_q;

endmodule

// File: rtl/spi_sample_receiver.sv
// Device-side SPI receiver: mode 0, MSB first, valid/ready output buffer
// with sticky overrun and frame-error pulse. SPI_RX_SYNC_EN adds pin synchronizers.
module spi_sample_receiver
    import spi_rx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  spi_clk_i,
    input  logic                  spi_mosi_i,
    input  logic                  spi_cs_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  overrun_o,
    output logic                  frame_err_o,
    input  logic                  clear_i
);

    localparam int unsigned       CW   = clog2(DATA_WIDTH);
    localparam logic [CW-1:0]     LAST = CW'(DATA_WIDTH - 1);

    logic                  s_mosi;
    logic                  s_cs;
    logic                  rise;
    state_t                state;
    logic [CW-1:0]         bitcnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] word;
    logic                  word_done;
    logic                  drop;

    spi_rx_frontend u_frontend (
        .clk        (clk),
        .rst_n      (rst_n),
        .spi_clk_i  (spi_clk_i),
        .spi_mosi_i (spi_mosi_i),
        .spi_cs_i   (spi_cs_i),
        .mosi       (s_mosi),
        .cs         (s_cs),
        .rise       (rise)
    );

    // cs high wins over a coincident clock rise, so a completing edge is lost.
    always_comb begin
        word      = {shreg[DATA_WIDTH-2:0], s_mosi};
        word_done = (state == ST_SHIFT) && !s_cs && rise && (bitcnt == LAST);
        drop      = word_done && valid_o && !ready_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            bitcnt      <= '0;
            shreg       <= '0;
            frame_err_o <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!s_cs) state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (s_cs) begin
                        state       <= ST_IDLE;
                        frame_err_o <= (bitcnt != '0);
                        bitcnt      <= '0;
                    end else if (rise) begin
                        shreg  <= word;
                        bitcnt <= (bitcnt == LAST) ? '0 : bitcnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_o    <= '0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            if (word_done) begin
                if (!valid_o || ready_i) begin
                    data_o  <= word;
                    valid_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end

            if (clear_i)   overrun_o <= 1'b0;
            else if (drop) overrun_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_spi_sample_receiver.sv
// Directed and randomized bench for spi_sample_receiver; latency expectations follow SPI_RX_SYNC_EN.
module tb_spi_sample_receiver;

    localparam int unsigned DW = 8;
`ifdef SPI_RX_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          spi_clk  = 1'b0;
    logic          spi_mosi = 1'b0;
    logic          spi_cs   = 1'b1;
    logic          ready    = 1'b1;
    logic          clear    = 1'b0;
    logic [DW-1:0] data;
    logic          valid;
    logic          overrun;
    logic          frame_err;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] rx_q[$];
    logic [DW-1:0] exp_q[$];
    int            vcnt = 0;
    int            fe_cnt = 0;
    int            lat_seen;
    int            fe_at;
    logic          post_valid;
    logic [DW-1:0] post_data;

    always #5 clk = ~clk;

    spi_sample_receiver #(.DATA_WIDTH(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_clk_i   (spi_clk),
        .spi_mosi_i  (spi_mosi),
        .spi_cs_i    (spi_cs),
        .data_o      (data),
        .valid_o     (valid),
        .ready_i     (ready),
        .overrun_o   (overrun),
        .frame_err_o (frame_err),
        .clear_i     (clear)
    );

    // Inputs change 2 time units after posedge, so at negedge ready is the
    // value the next posedge will see, and a word is consumed there.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) vcnt++;
            if (frame_err) fe_cnt++;
            if (valid && ready) rx_q.push_back(data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_bits(input logic [DW-1:0] w, input int unsigned n,
                             input bit cs_last, input bit ready_hit);
        for (int unsigned i = 0; i < n; i++) begin
            spi_mosi = w[DW-1-i];
            spi_clk  = 1'b0;
            repeat (4) tick();
            spi_clk = 1'b1;
            if (cs_last && i == n - 1) spi_cs = 1'b1;
            if (i == n - 1) lat_seen = 0;
            for (int k = 1; k <= 4; k++) begin
                if (ready_hit && i == n - 1 && k == LAT) ready = 1'b1;
                tick();
                if (i == n - 1 && valid && lat_seen == 0) lat_seen = k;
                if (ready_hit && i == n - 1 && k == LAT) begin
                    post_valid = valid;
                    post_data  = data;
                    ready      = 1'b0;
                end
            end
        end
        spi_clk = 1'b0;
    endtask

    task automatic begin_frame();
        spi_cs = 1'b0;
        repeat (3) tick();
    endtask

    task automatic end_frame();
        repeat (2) tick();
        spi_cs = 1'b1;
        fe_at  = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (frame_err && fe_at == 0) fe_at = k;
        end
    endtask

    initial begin
        int r0;
        int f0;
        int v0;
        int fe_exp;
        int unsigned n;
        int unsigned partial;
        logic [DW-1:0] w;

        // Reset state
        repeat (3) tick();
        check("rst_data", 32'(data), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single word 0xA5, ready held high
        ready = 1'b1;
        v0 = vcnt;
        r0 = rx_q.size();
        begin_frame();
        send_bits(8'hA5, DW, 1'b0, 1'b0);
        check("t1_latency", 32'(lat_seen), 32'(LAT));
        end_frame();
        check("t1_data", 32'(data), 32'hA5);
        check("t1_valid_cycles", 32'(vcnt - v0), 32'd1);
        check("t1_rx_count", 32'(rx_q.size() - r0), 32'd1);
        check("t1_rx_word", 32'(rx_q[r0]), 32'hA5);
        check("t1_overrun", 32'(overrun), 32'h0);
        check("t1_no_frame_err", 32'(fe_at), 32'd0);

        // Three back-to-back words with the consumer stalled
        ready = 1'b0;
        begin_frame();
        send_bits(8'h12, DW, 1'b0, 1'b0);
        send_bits(8'h34, DW, 1'b0, 1'b0);
        send_bits(8'h56, DW, 1'b0, 1'b0);
        end_frame();
        check("t2_data", 32'(data), 32'h12);
        check("t2_valid", 32'(valid), 32'h1);
        check("t2_overrun", 32'(overrun), 32'h1);
        check("t2_no_frame_err", 32'(fe_at), 32'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("t2_overrun_cleared", 32'(overrun), 32'h0);
        ready = 1'b1;
        tick();
        check("t2_valid_consumed", 32'(valid), 32'h0);
        check("t2_data_held", 32'(data), 32'h12);

        // cs released after 5 bits, then a clean frame
        f0 = fe_cnt;
        v0 = vcnt;
        begin_frame();
        send_bits(8'hFF, 5, 1'b0, 1'b0);
        end_frame();
        check("t3_frame_err_latency", 32'(fe_at), 32'(LAT));
        check("t3_frame_err_pulses", 32'(fe_cnt - f0), 32'd1);
        check("t3_no_valid", 32'(vcnt - v0), 32'd0);
        r0 = rx_q.size();
        begin_frame();
        send_bits(8'h3C, DW, 1'b0, 1'b0);
        end_frame();
        check("t3_rx_count", 32'(rx_q.size() - r0), 32'd1);
        check("t3_rx_word", 32'(rx_q[r0]), 32'h3C);

        // Last clock rise coincides with cs release
        f0 = fe_cnt;
        v0 = vcnt;
        r0 = rx_q.size();
        begin_frame();
        send_bits(8'h96, DW, 1'b1, 1'b0);
        end_frame();
        check("t4_frame_err_pulses", 32'(fe_cnt - f0), 32'd1);
        check("t4_no_valid", 32'(vcnt - v0), 32'd0);
        check("t4_no_word", 32'(rx_q.size() - r0), 32'd0);

        // Reset mid-word with a full buffer and overrun set
        ready = 1'b0;
        begin_frame();
        send_bits(8'h77, DW, 1'b0, 1'b0);
        send_bits(8'h66, DW, 1'b0, 1'b0);
        check("t5_pre_overrun", 32'(overrun), 32'h1);
        send_bits(8'hF0, 4, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check("t5_rst_data", 32'(data), 32'h0);
        check("t5_rst_valid", 32'(valid), 32'h0);
        check("t5_rst_overrun", 32'(overrun), 32'h0);
        check("t5_rst_frame_err", 32'(frame_err), 32'h0);
        spi_cs = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        ready = 1'b1;
        r0 = rx_q.size();
        begin_frame();
        send_bits(8'h81, DW, 1'b0, 1'b0);
        end_frame();
        check("t5_rx_count", 32'(rx_q.size() - r0), 32'd1);
        check("t5_rx_word", 32'(rx_q[r0]), 32'h81);
        check("t5_no_frame_err", 32'(fe_at), 32'd0);

        // Completion in the same cycle the previous word is consumed
        ready = 1'b0;
        r0 = rx_q.size();
        begin_frame();
        send_bits(8'h5A, DW, 1'b0, 1'b0);
        check("t6_first_valid", 32'(valid), 32'h1);
        send_bits(8'hC3, DW, 1'b0, 1'b1);
        check("t6_valid_kept", 32'(post_valid), 32'h1);
        check("t6_new_data", 32'(post_data), 32'hC3);
        check("t6_no_overrun", 32'(overrun), 32'h0);
        ready = 1'b1;
        end_frame();
        check("t6_rx_count", 32'(rx_q.size() - r0), 32'd2);
        check("t6_rx_first", 32'(rx_q[r0]), 32'h5A);
        check("t6_rx_second", 32'(rx_q[r0+1]), 32'hC3);

        // Randomized frames: each full word must arrive in order, each
        // trailing partial word must give exactly one frame error
        ready  = 1'b1;
        r0     = rx_q.size();
        f0     = fe_cnt;
        fe_exp = 0;
        exp_q.delete();
        for (int it = 0; it < 12; it++) begin
            n       = $urandom_range(3, 1);
            partial = ($urandom_range(1, 0) == 1) ? $urandom_range(DW - 1, 1) : 0;
            begin_frame();
            for (int unsigned j = 0; j < n; j++) begin
                w = DW'($urandom);
                exp_q.push_back(w);
                send_bits(w, DW, 1'b0, 1'b0);
            end
            if (partial != 0) begin
                w = DW'($urandom);
                send_bits(w, partial, 1'b0, 1'b0);
                fe_exp++;
            end
            end_frame();
        end
        check("rand_rx_count", 32'(rx_q.size() - r0), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("rand_word_%0d", i), 32'(rx_q[r0+i]), 32'(exp_q[i]));
        end
        check("rand_frame_errs", 32'(fe_cnt - f0), 32'(fe_exp));
        check("rand_overrun", 32'(overrun), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
